// File: rtl/mux4_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux4_rr_arbiter
//   Round-robin arbiter and select sequencer for a 4:1 mux. Four requesters
//   share one mux output. One requester is granted at a time. Each tenure is
//   bounded to MAX_HOLD cycles. The mux selects come from registered state.
//
// Parameters
//   MAX_HOLD : maximum consecutive cycles of one grant (legal range 1..15).
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous assert, active-low reset
//   req[3:0]   in   request vector, req[i] belongs to data di
//   d0..d3     in   requester data
//   lock       in   (only with MUX4_ARB_LOCK_EN) extends the tenure past MAX_HOLD
//   gnt[3:0]   out  one-hot grant, registered
//   s1, s0     out  mux select MSB/LSB, registered
//   valid      out  high while a grant is held, registered
//   y          out  data of the current owner when valid, else 0
//
// Optional feature macro: MUX4_ARB_LOCK_EN
// ---------------------------------------------------------------------------
module mux4_rr_arbiter #(
  parameter int MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       d0,
  input  logic       d1,
  input  logic       d2,
  input  logic       d3,
`ifdef MUX4_ARB_LOCK_EN
  input  logic       lock,
`endif
  output logic [3:0] gnt,
  output logic       s0,
  output logic       s1,
  output logic       valid,
  output logic       y
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [3:0] MAX_HOLD_C = 4'(MAX_HOLD);

  state_t     state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] sel_q, sel_d;
  logic       valid_q, valid_d;
  logic [3:0] hold_cnt_q, hold_cnt_d;
  logic [1:0] last_ptr_q, last_ptr_d;

  logic [2:0] pick_idle, pick_end;
  logic       lock_act;
  logic       tenure_end;
  logic       mux_out;

  // Returns {found, index}. Search starts one past ptr and wraps. The loop
  // runs from the farthest offset to the nearest, so the nearest set bit
  // writes last and wins.
  function automatic logic [2:0] rr_pick(input logic [1:0] ptr, input logic [3:0] r);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int i = 4; i >= 1; i--) begin
      idx = ptr + 2'(i);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

`ifdef MUX4_ARB_LOCK_EN
  // lock only matters during a tenure. In IDLE, BUSY logic is not evaluated.
  assign lock_act = lock;
`else
  assign lock_act = 1'b0;
`endif

  // In BUSY, the owner index is the registered select value.
  assign pick_idle  = rr_pick(last_ptr_q, req);
  assign pick_end   = rr_pick(sel_q, req);
  assign tenure_end = !req[sel_q] || ((hold_cnt_q == MAX_HOLD_C) && !lock_act);

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    sel_d      = sel_q;
    valid_d    = valid_q;
    hold_cnt_d = hold_cnt_q;
    last_ptr_d = last_ptr_q;
    case (state_q)
      IDLE: begin
        if (pick_idle[2]) begin
          state_d    = BUSY;
          gnt_d      = 4'b0001 << pick_idle[1:0];
          sel_d      = pick_idle[1:0];
          valid_d    = 1'b1;
          hold_cnt_d = 4'd1;
        end
      end
      BUSY: begin
        if (tenure_end) begin
          // The owner becomes lowest priority. Re-arbitrate on the same
          // edge, so back-to-back grants have no bubble cycle.
          last_ptr_d = sel_q;
          if (pick_end[2]) begin
            gnt_d      = 4'b0001 << pick_end[1:0];
            sel_d      = pick_end[1:0];
            hold_cnt_d = 4'd1;
          end else begin
            state_d = IDLE;
            gnt_d   = 4'b0000;
            valid_d = 1'b0;
          end
        end else begin
          // The count saturates only when lock holds the tenure past MAX_HOLD.
          hold_cnt_d = (hold_cnt_q == MAX_HOLD_C) ? hold_cnt_q : hold_cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gnt_q      <= 4'b0000;
      sel_q      <= 2'b00;
      valid_q    <= 1'b0;
      hold_cnt_q <= 4'd0;
      last_ptr_q <= 2'd3;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      sel_q      <= sel_d;
      valid_q    <= valid_d;
      hold_cnt_q <= hold_cnt_d;
      last_ptr_q <= last_ptr_d;
    end
  end

  always_comb begin
    case (sel_q)
      2'd0:    mux_out = d0;
      2'd1:    mux_out = d1;
      2'd2:    mux_out = d2;
      default: mux_out = d3;
    endcase
  end

  assign gnt   = gnt_q;
  assign s1    = sel_q[1];
  assign s0    = sel_q[0];
  assign valid = valid_q;
  assign y     = valid_q & mux_out;

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter and select sequencer for the gate-level 4:1 mux (inputs d0..d3, selects s1/s0, output y).
- Four requesters share the single mux output. The block grants one requester at a time, drives the mux select lines from registered state, and bounds each tenure to MAX_HOLD cycles.
- Sits directly in front of the mux. s1/s0 connect straight to the mux selects.

Parameters:
- MAX_HOLD, 4, maximum consecutive cycles a single grant lasts; legal range 1..15; the hold counter is 4 bits.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  reset, asynchronous assert, active-low
- req  input  4  request vector; req[i] belongs to requester i (data di)
- d0  input  1  requester 0 data
- d1  input  1  requester 1 data
- d2  input  1  requester 2 data
- d3  input  1  requester 3 data
- gnt  output  4  one-hot grant, registered
- s0  output  1  mux select LSB, registered
- s1  output  1  mux select MSB, registered
- valid  output  1  high while any gnt bit is high, registered
- y  output  1  muxed data of owner when valid, else 0 (combinational from registered selects)

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. rst_n low forces the state immediately; release is sampled on clk.
- Reset values:
  - state=IDLE, gnt=4'b0000, s1=0, s0=0, valid=0, y=0
  - hold_cnt=0, last_ptr=3, so requester 0 has first priority.
- Select encoding (matches the mux): owner 0 gives s1s0=00, 1 gives 01, 2 gives 10, 3 gives 11.
- Arbitration:
  - Search req starting at last_ptr+1 (mod 4), wrapping.
  - The first set bit wins.
  - Pure combinational pick; the result is registered.
- States:
  - IDLE:
    - req==0: stay in IDLE, outputs idle.
    - req!=0: next edge loads gnt/s1/s0 for the winner, sets valid=1, hold_cnt=1, and moves to BUSY.
    - Grant latency is 1 cycle from req sampled high.
  - BUSY, owner k: the tenure ends on the edge where req[k] is sampled low, or on the edge where hold_cnt==MAX_HOLD. At the end of tenure:
    - last_ptr<=k.
    - Re-arbitrate in the same cycle with the new pointer. If any req is set, load the new grant on that edge: no bubble cycle, hold_cnt<=1.
    - Otherwise return to IDLE with gnt=0, valid=0, s1s0 held at previous value.
    - If the tenure continues, hold_cnt increments.
- Fairness:
  - At MAX_HOLD expiry, k is lowest priority.
  - If k is the only requester, it is re-granted back-to-back and hold_cnt restarts at 1.
- MAX_HOLD=1: every cycle is a new arbitration, giving strict per-cycle round robin.
- A request dropping while ungranted has no effect. A request appearing mid-tenure waits for the tenure end.
- Invariants:
  - gnt is always one-hot or zero.
  - s1s0 always equals the encoded index of the set gnt bit when valid=1.
- Reset mid-tenure: grant drops immediately (asynchronously) and the pointer returns to 3.

Optional Feature:
- Macro: MUX4_ARB_LOCK_EN.
- Defined:
  - Adds input port lock (1 bit).
  - While valid=1 and lock=1, the MAX_HOLD expiry is suppressed: hold_cnt saturates at MAX_HOLD and the tenure ends only when req[k] drops.
  - lock is ignored in IDLE.
- Not defined:
  - No lock port.
  - Tenure always ends at MAX_HOLD.

Test Plan:
- Reset then idle: rst_n low→high, req=0000 for 5 cycles -> gnt=0000, valid=0, s1s0=00, y=0 throughout.
- Single request: req=0100, d2=1 -> one cycle later gnt=0100, s1s0=10, valid=1, y=1. Hold req; after 4 cycles (MAX_HOLD=4) it is re-granted with no gap, gnt stays 0100 and the counter restarts.
- Rotation: req=1111 held, MAX_HOLD=4 -> gnt sequence 0001,0010,0100,1000,0001, each held 4 cycles. s1s0 follows 00,01,10,11, no idle cycle between grants.
- Early release: gnt=0010, drop req[1] in cycle 2 of tenure while req[3]=1 -> next edge gnt=1000, s1s0=11. req[2] raised later is served after requester 3.
- Async reset mid-tenure: gnt=1000, pull rst_n low between edges -> gnt=0000, valid=0 without a clock edge. After release with req=1111, the first grant is 0001.
- With MUX4_ARB_LOCK_EN: req=0011, owner 0, lock=1 for 10 cycles -> gnt=0001 for all 10 cycles. After lock=0 at saturated count, the next edge grants 0010.
